// File: rtl/line_buf_rotator.sv
// Three-bank rotating line buffer feeding the 3x3 window stage.
// Each accepted pixel reads all banks at the current column and writes the bank owned by the current line.

module line_bank #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage is deliberately left unreset; line_cnt gating keeps stale words unselected.
    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= wdata;
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr)      q <= '0;
        else if (rd_en) q <= wr_en ? wdata : mem[addr];
    end
endmodule

module line_buf_rotator #(
    parameter int LINE_WIDTH = 640,
    parameter int ADDR_W     = 10
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic        iFVAL,
    input  logic        iDVAL,
    input  logic [9:0]  iDATA,
    output logic [9:0]  rama,
    output logic [9:0]  ramb,
    output logic [9:0]  ramc,
    output logic [1:0]  sel_row1,
    output logic [1:0]  sel_row2,
    output logic [1:0]  sel_row3,
    output logic        row_end,
    output logic        oDVAL
);
    localparam int NUM_BANKS = 3;
    localparam int DATA_W    = 10;
    localparam int STAGES    = 1;

    localparam logic [1:0] BANK_IDLE = 2'd0;
    localparam logic [1:0] BANK_A    = 2'd1;
    localparam logic [1:0] BANK_B    = 2'd2;
    localparam logic [1:0] BANK_C    = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_WIDTH - 1);

    logic [ADDR_W-1:0]                  col;
    logic [1:0]                         wr_bank;
    logic [1:0]                         line_cnt;
    logic [1:0]                         prev_bank;
    logic [1:0]                         prev2_bank;
    logic [1:0]                         next_bank;
    logic                               acc;
    logic                               last_col;
    logic [STAGES:0]                    vld_pipe;
    logic [NUM_BANKS-1:0][DATA_W-1:0]   bank_q;

    assign acc         = iFVAL & iDVAL;
    assign last_col    = (col == LAST_COL);
    assign vld_pipe[0] = acc;

    genvar g;
    generate
        for (g = 0; g < NUM_BANKS; g++) begin : g_bank
            line_bank #(
                .DATA_W(DATA_W),
                .ADDR_W(ADDR_W)
            ) u_bank (
                .clk   (clk),
                .aclr  (aclr),
                .rd_en (acc),
                .wr_en (acc && (wr_bank == 2'(g + 1))),
                .addr  (col),
                .wdata (iDATA),
                .q     (bank_q[g])
            );
        end
    endgenerate

    assign rama = bank_q[0];
    assign ramb = bank_q[1];
    assign ramc = bank_q[2];

    // Rotating back by two is the same as rotating forward by one.
    always_comb begin
        prev_bank  = BANK_C;
        prev2_bank = BANK_B;
        next_bank  = BANK_B;
        case (wr_bank)
            BANK_B: begin prev_bank = BANK_A; prev2_bank = BANK_C; next_bank = BANK_C; end
            BANK_C: begin prev_bank = BANK_B; prev2_bank = BANK_A; next_bank = BANK_A; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            col      <= '0;
            line_cnt <= '0;
            wr_bank  <= BANK_A;
        end else if (!iFVAL) begin
            col      <= '0;
            line_cnt <= '0;
            wr_bank  <= BANK_A;
        end else if (acc) begin
            if (last_col) begin
                col      <= '0;
                wr_bank  <= next_bank;
                line_cnt <= (line_cnt == 2'd2) ? 2'd2 : line_cnt + 2'd1;
            end else begin
                col <= col + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            sel_row1         <= BANK_IDLE;
            sel_row2         <= BANK_IDLE;
            sel_row3         <= BANK_IDLE;
            row_end          <= 1'b0;
            vld_pipe[STAGES] <= 1'b0;
        end else begin
            vld_pipe[STAGES] <= vld_pipe[STAGES-1];
            if (acc) begin
                sel_row3 <= wr_bank;
                sel_row2 <= (line_cnt != 2'd0) ? prev_bank  : BANK_IDLE;
                sel_row1 <= (line_cnt == 2'd2) ? prev2_bank : BANK_IDLE;
                row_end  <= last_col;
            end else begin
                sel_row1 <= BANK_IDLE;
                sel_row2 <= BANK_IDLE;
                sel_row3 <= BANK_IDLE;
                row_end  <= 1'b0;
            end
        end
    end

    assign oDVAL = vld_pipe[STAGES];
endmodule

// File: tb/tb_line_buf_rotator.sv
// Bench for line_buf_rotator: fixed vector table, directed corner sequences and random traffic vs a line-index model.

module tb_line_buf_rotator;
    localparam int LW = 4;

    logic       clk = 1'b0;
    logic       aclr;
    logic       iFVAL, iDVAL;
    logic [9:0] iDATA;
    logic [9:0] rama, ramb, ramc;
    logic [1:0] sel_row1, sel_row2, sel_row3;
    logic       row_end, oDVAL;

    line_buf_rotator #(.LINE_WIDTH(LW), .ADDR_W(10)) dut (
        .clk(clk), .aclr(aclr), .iFVAL(iFVAL), .iDVAL(iDVAL), .iDATA(iDATA),
        .rama(rama), .ramb(ramb), .ramc(ramc),
        .sel_row1(sel_row1), .sel_row2(sel_row2), .sel_row3(sel_row3),
        .row_end(row_end), .oDVAL(oDVAL)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: line k of a frame lives in bank k%3; memory persists across frames and resets.
    int        m_col, m_k;
    logic [9:0] mmem [3][LW];
    bit         mval [3][LW];
    logic [9:0] e_data [3];
    bit         e_dv   [3];
    int         e_s1, e_s2, e_s3, e_re, e_dval;

    typedef struct {
        bit f, d; logic [9:0] x;
        bit dv, re; int s1, s2, s3;
        int a, b, c; bit [2:0] m;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bank_of(input int k);
        return (k % 3) + 1;
    endfunction

    task automatic cmp_model(input string tag);
        chk({tag, " oDVAL"}, int'(oDVAL), e_dval);
        chk({tag, " row_end"}, int'(row_end), e_re);
        chk({tag, " sel_row1"}, int'(sel_row1), e_s1);
        chk({tag, " sel_row2"}, int'(sel_row2), e_s2);
        chk({tag, " sel_row3"}, int'(sel_row3), e_s3);
        if (e_dv[0]) chk({tag, " rama"}, int'(rama), int'(e_data[0]));
        if (e_dv[1]) chk({tag, " ramb"}, int'(ramb), int'(e_data[1]));
        if (e_dv[2]) chk({tag, " ramc"}, int'(ramc), int'(e_data[2]));
    endtask

    task automatic step(input bit f, input bit d, input logic [9:0] x, input string tag);
        int b;
        iFVAL = f; iDVAL = d; iDATA = x;
        if (f && d) begin
            b = m_k % 3;
            for (int i = 0; i < 3; i++) begin
                if (i == b) begin e_data[i] = x; e_dv[i] = 1'b1; end
                else begin e_data[i] = mmem[i][m_col]; e_dv[i] = mval[i][m_col]; end
            end
            mmem[b][m_col] = x;
            mval[b][m_col] = 1'b1;
            e_s3 = bank_of(m_k);
            e_s2 = (m_k >= 1) ? bank_of(m_k + 2) : 0;
            e_s1 = (m_k >= 2) ? bank_of(m_k + 1) : 0;
            e_re = (m_col == LW - 1) ? 1 : 0;
            e_dval = 1;
            m_col++;
            if (m_col == LW) begin m_col = 0; m_k++; end
        end else begin
            e_s1 = 0; e_s2 = 0; e_s3 = 0; e_re = 0; e_dval = 0;
        end
        if (!f) begin m_col = 0; m_k = 0; end
        @(posedge clk); #1;
        cmp_model(tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " rama"}, int'(rama), 0);
        chk({tag, " ramb"}, int'(ramb), 0);
        chk({tag, " ramc"}, int'(ramc), 0);
        chk({tag, " sels"}, int'({sel_row1, sel_row2, sel_row3}), 0);
        chk({tag, " row_end"}, int'(row_end), 0);
        chk({tag, " oDVAL"}, int'(oDVAL), 0);
    endtask

    // Asserts aclr between edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        aclr = 1'b0;
        #2;
        chk_zero({tag, " async"});
        for (int i = 0; i < 3; i++) begin
            iFVAL = 1'b1; iDVAL = i[0]; iDATA = 10'h2AA;
            @(posedge clk); #1;
            chk_zero({tag, " held"});
        end
        aclr = 1'b1;
        m_col = 0; m_k = 0;
        for (int i = 0; i < 3; i++) begin e_data[i] = '0; e_dv[i] = 1'b1; end
    endtask

    task automatic first_pixel(input string tag);
        step(1, 1, 10'h155, tag);
        chk({tag, " oDVAL"}, int'(oDVAL), 1);
        chk({tag, " rama"}, int'(rama), 'h155);
        chk({tag, " sel"}, int'({sel_row1, sel_row2, sel_row3}), 6'b00_00_01);
    endtask

    initial begin
        aclr = 1'b1; iFVAL = 1'b0; iDVAL = 1'b0; iDATA = '0;
        for (int i = 0; i < 3; i++) for (int j = 0; j < LW; j++) mval[i][j] = 1'b0;

        // Lines 0..3 streamed continuously; mask bits flag which banks hold known data.
        for (int c = 0; c < 4; c++) begin
            tbl[c]      = '{1, 1, 10'(c + 1),  1, c == 3, 0, 0, 1, c + 1, 0, 0, 3'b001};
            tbl[4 + c]  = '{1, 1, 10'(c + 11), 1, c == 3, 0, 1, 2, c + 1, c + 11, 0, 3'b011};
            tbl[8 + c]  = '{1, 1, 10'(c + 21), 1, c == 3, 1, 2, 3, c + 1, c + 11, c + 21, 3'b111};
            tbl[12 + c] = '{1, 1, 10'(c + 31), 1, c == 3, 2, 3, 1, c + 31, c + 11, c + 21, 3'b111};
        end

        @(posedge clk); #1;
        do_reset("rst0");
        first_pixel("first");

        step(0, 0, 0, "fclr");
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].f, tbl[i].d, tbl[i].x, "tblmodel");
            chk($sformatf("tbl%0d oDVAL", i), int'(oDVAL), int'(tbl[i].dv));
            chk($sformatf("tbl%0d row_end", i), int'(row_end), int'(tbl[i].re));
            chk($sformatf("tbl%0d sel", i), int'({sel_row1, sel_row2, sel_row3}),
                (tbl[i].s1 << 4) | (tbl[i].s2 << 2) | tbl[i].s3);
            if (tbl[i].m[0]) chk($sformatf("tbl%0d rama", i), int'(rama), tbl[i].a);
            if (tbl[i].m[1]) chk($sformatf("tbl%0d ramb", i), int'(ramb), tbl[i].b);
            if (tbl[i].m[2]) chk($sformatf("tbl%0d ramc", i), int'(ramc), tbl[i].c);
        end

        // Blanking gaps between every pixel of line1.
        step(0, 0, 0, "fclr2");
        for (int c = 0; c < LW; c++) step(1, 1, 10'(c + 1), "gap l0");
        for (int c = 0; c < LW; c++) begin
            step(1, 1, 10'(c + 11), "gap l1");
            chk("gap l1 ramb", int'(ramb), c + 11);
            step(1, 0, 10'h3C3, "gap idle");
            chk("gap idle oDVAL", int'(oDVAL), 0);
        end
        for (int c = 0; c < LW; c++) step(1, 1, 10'(c + 21), "gap l2");
        chk("gap l2 last sel", int'({sel_row1, sel_row2, sel_row3}), 6'b01_10_11);

        // Partial line3 abandoned, then a fresh frame.
        step(1, 1, 10'd31, "part");
        step(1, 1, 10'd32, "part");
        chk("part row_end", int'(row_end), 0);
        step(0, 1, 10'd33, "fdrop");
        chk("fdrop row_end", int'(row_end), 0);
        step(1, 1, 10'h3FF, "restart");
        chk("restart sel", int'({sel_row1, sel_row2, sel_row3}), 6'b00_00_01);
        chk("restart rama", int'(rama), 'h3FF);
        chk("restart row_end", int'(row_end), 0);

        // Last pixel accepted in the final iFVAL-high cycle.
        for (int c = 1; c < LW; c++) step(1, 1, 10'(c + 40), "lastfall");
        chk("lastfall row_end", int'(row_end), 1);
        step(0, 0, 0, "lastfall clr");
        step(1, 1, 10'd50, "lastfall new");
        chk("lastfall new sel", int'({sel_row1, sel_row2, sel_row3}), 6'b00_00_01);

        // Reset mid-line at line1 col2.
        step(0, 0, 0, "fclr3");
        for (int c = 0; c < LW; c++) step(1, 1, 10'(c + 60), "mid l0");
        step(1, 1, 10'd70, "mid l1");
        step(1, 1, 10'd71, "mid l1");
        do_reset("rst1");
        first_pixel("first2");

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0, 10'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
